// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC holder, single-beat read, decode handoff
// One read in flight at a time; the next PC is looped back from writeback before refetch.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_pre_i,
  input  logic [XLEN-1:0] dnpc_i,
  output logic            ready_pre_o,
  output logic            arvalid_o,
  output logic [XLEN-1:0] araddr_o,
  input  logic            arready_i,
  input  logic            rvalid_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rresp_i,
  output logic            rready_o,
  output logic            valid_post_o,
  input  logic            ready_post_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic [1:0]      fault_o,
  output logic [63:0]     fetch_cnt_o
);

  typedef enum logic [2:0] {BOOT, ADDR, DATA, SEND, WAIT_PC} state_t;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_MISAL  = 2'b10;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [1:0]      fault_q, fault_d;
  logic [63:0]     fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      fault_q     <= FAULT_NONE;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      BOOT: state_d = ADDR;
      ADDR: if (arready_i) state_d = DATA;
      DATA: if (rvalid_i) begin
        state_d = SEND;
        inst_d  = rdata_i;
        fault_d = (rresp_i != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
      end
      SEND: if (ready_post_i) begin
        state_d     = WAIT_PC;
        fetch_cnt_d = fetch_cnt_q + 64'd1;
      end
      WAIT_PC: if (valid_pre_i) begin
        pc_d = dnpc_i;
        // A misaligned target never reaches memory; decode gets the fault directly.
        if (dnpc_i[1:0] == 2'b00) begin
          state_d = ADDR;
        end else begin
          state_d = SEND;
          inst_d  = '0;
          fault_d = FAULT_MISAL;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign arvalid_o    = (state_q == ADDR);
  assign rready_o     = (state_q == DATA);
  assign valid_post_o = (state_q == SEND);
  assign ready_pre_o  = (state_q == WAIT_PC);
  assign araddr_o     = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign fault_o      = fault_q;
  assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage of the multi-cycle NPC core. It sits directly upstream of the decode stage.
- Holds the PC and issues a single-beat instruction read on a valid/ready address/data memory channel.
- Hands {pc, inst, fault} to decode with a valid/ready handshake.
- Waits for the next PC, which is looped back from writeback, before fetching again.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
XLEN, 32, width of PC, address and instruction.

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
valid_pre_i  in  1  next-PC valid from writeback
dnpc_i  in  XLEN  next PC
ready_pre_o  out  1  fetch ready to accept next PC
arvalid_o  out  1  read address valid
araddr_o  out  XLEN  read address
arready_i  in  1  memory accepts address
rvalid_i  in  1  read data valid
rdata_i  in  XLEN  read data
rresp_i  in  2  read response; 00 = OKAY
rready_o  out  1  fetch accepts read data
valid_post_o  out  1  instruction valid to decode
ready_post_i  in  1  decode ready
pc_o  out  XLEN  PC of the presented instruction
inst_o  out  XLEN  fetched instruction
fault_o  out  2  00 none, 01 access fault, 10 misaligned PC
fetch_cnt_o  out  64  count of instructions accepted by decode

Behaviour:
- Reset (asynchronous, immediate):
  - state = BOOT; pc = RESET_PC; inst = 0; fault = 00; fetch_cnt = 0.
  - arvalid_o, rready_o, valid_post_o and ready_pre_o are all 0.
- States: BOOT, ADDR, DATA, SEND, WAIT_PC. Outputs are decoded from the registered state only:
  - arvalid_o = (state==ADDR)
  - rready_o = (state==DATA)
  - valid_post_o = (state==SEND)
  - ready_pre_o = (state==WAIT_PC)
- araddr_o = pc_o = pc register. pc is stable throughout ADDR/DATA/SEND.
- Transitions:
  - BOOT -> ADDR: unconditional, first cycle after reset release.
  - ADDR -> DATA: when arready_i.
  - DATA -> SEND: when rvalid_i. On that edge, inst <= rdata_i, and fault <= 01 if rresp_i != 00, else 00.
  - SEND -> WAIT_PC: when ready_post_i. On that edge, fetch_cnt increments by 1 (wraps modulo 2^64).
  - WAIT_PC, valid_pre_i with dnpc_i[1:0]==00: pc <= dnpc_i; go to ADDR.
  - WAIT_PC, valid_pre_i with dnpc_i[1:0]!=00: pc <= dnpc_i; inst <= 0; fault <= 10; go directly to SEND. No memory request is issued.
- inst_o and fault_o hold their values until next overwritten.
- Inputs outside their owning state are ignored:
  - rvalid_i while in ADDR
  - arready_i while in DATA
  - valid_pre_i while not in WAIT_PC
  - ready_post_i while not in SEND
- No combinational path from any input to any handshake output.
- Minimum latency: next-PC handshake at edge t; arvalid high in cycle t+1; with arready_i=1 and then rvalid_i=1 immediately, valid_post_o is high in cycle t+3.
- Exactly one outstanding read. After a fault, the stage still presents to decode and waits for a next PC; it never stalls on its own.
- Reset mid-transaction abandons the read with no retry of the old address. The next fetch is from RESET_PC after BOOT.

Test Plan:
- Boot: release reset, hold arready_i=1, rvalid_i=1, rdata_i=32'h0000_0413, rresp_i=00 -> arvalid_o rises 2nd cycle after release with araddr_o=0x8000_0000; valid_post_o rises 2 cycles later with inst_o=0x0000_0413 and fault_o=00.
- Backpressure: hold ready_post_i=0 for 5 cycles -> valid_post_o, pc_o and inst_o stay constant; fetch_cnt_o unchanged. Then ready_post_i=1 -> ready_pre_o=1 next cycle; fetch_cnt_o=1.
- Memory stalls: arready_i low 3 cycles, then rvalid_i low 4 cycles -> araddr_o stable throughout; rready_o asserts only after the address handshake; inst_o captured only on rvalid_i.
- Next PC: in WAIT_PC, drive valid_pre_i=1 with dnpc_i=0x8000_0004 -> arvalid_o=1 next cycle with araddr_o=0x8000_0004. Also drive valid_pre_i pulses during SEND -> they are ignored.
- Faults: rresp_i=10 -> fault_o=01. dnpc_i=0x8000_0006 -> no arvalid_o; valid_post_o next cycle with inst_o=0, fault_o=10.
- Reset mid-read: assert reset while in DATA -> rready_o and arvalid_o drop immediately; after release, refetch from 0x8000_0000 with fetch_cnt_o=0.
